// File: rtl/cm0ik_output_capture_pkg.sv
// cm0ik_output_capture_pkg: shared defaults and sizing helpers for the output capture block
package cm0ik_output_capture_pkg;
   localparam int DEF_BUSWIDTH   = 1;
   localparam int DEF_DEPTH      = 8;
   localparam int DEF_STAMPWIDTH = 16;
   // FIFO entries are packed {stamp, data}: stamp in the upper bits, data in the lower bits.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/cm0ik_output_capture_fifo.sv
// cm0ik_output_capture_fifo: first-word fall-through FIFO with push/pop/flush and entry count
//   clk, rst   : clock, async active-high reset
//   push, pop  : write wdata / advance head (pop ignored when empty)
//   flush      : empties the FIFO, overrides push and pop
//   rdata      : head entry, zero when empty
//   valid      : head entry present
//   count      : stored entries
module cm0ik_output_capture_fifo
   import cm0ik_output_capture_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int DEPTH = DEF_DEPTH,
   localparam int CW   = cnt_w(DEPTH),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             valid,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             do_pop, do_push;
   assign valid   = count != '0;
   assign do_pop  = pop && valid;
   // a full FIFO still accepts a write when the head leaves on the same edge
   assign do_push = push && (count != CW'(DEPTH) || do_pop);
   assign rdata   = valid ? mem[rptr] : '0;
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr] <= wdata;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/cm0ik_output_capture.sv
// cm0ik_output_capture: change-compressed, timestamped capture of a netlist output bus
//   HCLK, HRESET        : capture clock, async active-high reset
//   datain, sample_en   : bus under capture and its sampling qualifier
//   flush               : drop stored entries and re-prime change detection
//   clr_overflow        : clears the sticky overflow flag (a same-cycle drop wins)
//   rd_ready            : consumer takes the head entry
//   rd_valid/data/stamp : head entry, zero when empty
//   count, overflow     : stored entries, sticky dropped-sample flag
module cm0ik_output_capture
   import cm0ik_output_capture_pkg::*;
#(
   parameter int BUSWIDTH   = DEF_BUSWIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int STAMPWIDTH = DEF_STAMPWIDTH,
   localparam int CW        = cnt_w(DEPTH)
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic [BUSWIDTH-1:0]   datain,
   input  logic                  sample_en,
   input  logic                  flush,
   input  logic                  clr_overflow,
   input  logic                  rd_ready,
   output logic                  rd_valid,
   output logic [BUSWIDTH-1:0]   rd_data,
   output logic [STAMPWIDTH-1:0] rd_stamp,
   output logic [CW-1:0]         count,
   output logic                  overflow
);
   logic [STAMPWIDTH-1:0] stamp;
   logic [BUSWIDTH-1:0]   last;
   logic                  primed, qual, pop, full, push, drop;
   assign qual = sample_en && (!primed || datain != last);
   assign pop  = rd_valid && rd_ready;
   assign full = count == CW'(DEPTH);
   assign push = qual && !flush && (!full || pop);
   assign drop = qual && !flush && full && !pop;
   cm0ik_output_capture_fifo #(
      .WIDTH(STAMPWIDTH + BUSWIDTH),
      .DEPTH(DEPTH)
   ) fifo (
      .clk  (HCLK),
      .rst  (HRESET),
      .push (push),
      .pop  (pop),
      .flush(flush),
      .wdata({stamp, datain}),
      .rdata({rd_stamp, rd_data}),
      .valid(rd_valid),
      .count(count)
   );
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         stamp    <= '0;
         last     <= '0;
         primed   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         stamp    <= stamp + STAMPWIDTH'(1);
         overflow <= drop || (overflow && !clr_overflow);
         // last/primed track every qualifying sample, even dropped ones
         if (flush) primed <= 1'b0;
         else if (qual) begin
            last   <= datain;
            primed <= 1'b1;
         end
      end
   end
endmodule
